// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared types, constants and step arithmetic for the
//               scan select sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHK_HI  = 2'd1,
        PRESSED = 2'd2,
        CHK_LO  = 2'd3
    } deb_state_t;

    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;
    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

    // Returns {wrap, next_sel}; wrap flags the 11->00 / 00->11 crossing.
    function automatic logic [2:0] f_sel_step(input logic [1:0] sel, input logic dir);
        logic [1:0] nxt;
        logic       wr;
        if (dir == DIR_UP) begin
            nxt = sel + 2'd1;
            wr  = (sel == 2'b11);
        end else begin
            nxt = sel - 2'd1;
            wr  = (sel == 2'b00);
        end
        return {wr, nxt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : btn_debouncer
// Description : Two-flop synchronizer plus debounce FSM; one pulse per
//               accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer
    import scan_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int DEB_WIDTH  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam logic [DEB_WIDTH-1:0] c_DEB_LAST = DEB_WIDTH'(DEB_CYCLES - 1);

    logic [1:0]           r_sync;
    deb_state_t           r_state;
    logic [DEB_WIDTH-1:0] r_cnt;
    logic                 r_pulse;
    logic                 w_btn_s;
    logic [DEB_WIDTH-1:0] w_cnt_inc;

    assign w_btn_s   = r_sync[1];
    assign w_cnt_inc = r_cnt + 1'b1;
    assign btn_pulse = r_pulse;

    // The entering edge counts as the first stable sample, so the level is
    // accepted on the edge where the incremented count hits DEB_CYCLES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_btn_s) begin
                        r_state <= CHK_HI;
                        r_cnt   <= '0;
                    end
                end
                CHK_HI: begin
                    if (!w_btn_s) begin
                        r_state <= IDLE;
                    end else if (w_cnt_inc == c_DEB_LAST) begin
                        r_state <= PRESSED;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!w_btn_s) begin
                        r_state <= CHK_LO;
                        r_cnt   <= '0;
                    end
                end
                CHK_LO: begin
                    if (w_btn_s) begin
                        r_state <= PRESSED;
                    end else if (w_cnt_inc == c_DEB_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_select_sequencer
// Description : Registered 2-bit A/B select source for the 2-to-4 decoder,
//               stepped by a prescaler tick or a debounced button.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_select_sequencer
    import scan_pkg::*;
#(
    parameter int DIV_MAX    = 99_999,
    parameter int DIV_WIDTH  = 17,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int DEB_WIDTH  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       dir,
    input  logic       load,
    input  logic [1:0] load_val,
    input  logic       step_btn,
    output logic       A,
    output logic       B,
    output logic       tick,
    output logic       wrap
);

    localparam logic [DIV_WIDTH-1:0] c_DIV_LAST = DIV_WIDTH'(DIV_MAX);

    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic [1:0]           r_sel;
    logic                 r_wrap;
    logic                 w_btn_pulse;
    logic                 w_step;
    logic [2:0]           w_next;

    btn_debouncer #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_WIDTH  (DEB_WIDTH)
    ) u_btn_debouncer (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (step_btn),
        .btn_pulse (w_btn_pulse)
    );

    assign tick   = en && (r_div_cnt == c_DIV_LAST);
    assign w_step = en && ((mode == MODE_AUTO) ? tick : w_btn_pulse);
    assign w_next = f_sel_step(r_sel, dir);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (en) begin
            r_div_cnt <= tick ? '0 : r_div_cnt + 1'b1;
        end
    end

    // Load outranks a coincident step and never raises wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel  <= 2'b00;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_sel  <= load_val;
            r_wrap <= 1'b0;
        end else if (w_step) begin
            r_sel  <= w_next[1:0];
            r_wrap <= w_next[2];
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign A    = r_sel[1];
    assign B    = r_sel[0];
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_select_sequencer
// Description : Scoreboard bench: expected {A,B,wrap,tick} queued per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_select_sequencer;

    localparam logic [3:0] c_FULL = 4'b1111;
    localparam logic [3:0] c_SEL  = 4'b1100;
    localparam logic [3:0] c_WRAP = 4'b0010;
    localparam logic [3:0] c_TICK = 4'b0001;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] mask;
        logic [3:0] val;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       rst, en, mode, dir, load, step_btn;
    logic [1:0] load_val;
    logic       A, B, tick, wrap;
    logic [3:0] w_obs;

    int       cyc   = 0;
    int       n_cmp = 0;
    int       n_err = 0;
    sb_item_t sb_q[$];

    scan_select_sequencer #(
        .DIV_MAX    (3),
        .DIV_WIDTH  (2),
        .DEB_CYCLES (4),
        .DEB_WIDTH  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .step_btn (step_btn),
        .A        (A),
        .B        (B),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign w_obs = {A, B, wrap, tick};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic exp_at(input int at, input string tag, input logic [3:0] mask, input logic [3:0] val);
        sb_item_t it;
        it.cyc  = at;
        it.tag  = tag;
        it.mask = mask;
        it.val  = val;
        sb_q.push_back(it);
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic to_cyc(input int target);
        while (cyc < target) adv(1);
    endtask

    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check_val(sb_q[i].tag, 32'(w_obs & sb_q[i].mask), 32'(sb_q[i].val & sb_q[i].mask));
                sb_q.delete(i);
            end else if (sb_q[i].cyc < cyc) begin
                check_val({sb_q[i].tag, "_missed"}, 32'(cyc), 32'(sb_q[i].cyc));
                sb_q.delete(i);
            end
        end
    end

    initial begin
        int t, r, b, m, r2;
        rst = 1'b1; en = 1'b1; mode = 1'b0; dir = 1'b0;
        load = 1'b0; load_val = 2'b00; step_btn = 1'b0;
        adv(2);

        // Reset state, then auto up-count with one wrap on 11->00
        t = cyc;
        exp_at(t, "rst_state", c_FULL, 4'b0000);
        rst = 1'b0;
        exp_at(t + 3,  "auto_tick",  c_FULL, 4'b0001);
        exp_at(t + 4,  "auto_01",    c_FULL, 4'b0100);
        exp_at(t + 8,  "auto_10",    c_FULL, 4'b1000);
        exp_at(t + 12, "auto_11",    c_FULL, 4'b1100);
        exp_at(t + 16, "auto_wrap",  c_FULL, 4'b0010);
        exp_at(t + 17, "wrap_once",  c_WRAP, 4'b0000);
        to_cyc(t + 17);

        // Down count across 00->11, then freeze with en=0 at div_cnt=2
        dir = 1'b1;
        exp_at(t + 20, "down_wrap", c_FULL, 4'b1110);
        to_cyc(t + 22);
        en = 1'b0;
        for (int k = 23; k <= 32; k++) exp_at(t + k, "en_hold", c_FULL, 4'b1100);
        to_cyc(t + 32);
        en = 1'b1;
        exp_at(t + 33, "resume_tick", c_FULL, 4'b1101);
        exp_at(t + 34, "resume_step", c_FULL, 4'b1000);

        // Load coincident with a tick wins and does not wrap
        exp_at(t + 37, "load_tick", c_TICK, 4'b0001);
        to_cyc(t + 37);
        load = 1'b1; load_val = 2'b10;
        exp_at(t + 38, "load_win", c_FULL, 4'b1000);
        to_cyc(t + 38);
        load = 1'b0;
        exp_at(t + 42, "post_load_step", c_FULL, 4'b0100);
        to_cyc(t + 42);

        // Manual mode: clean press gives exactly one step at rise+7
        mode = 1'b1; dir = 1'b0; load = 1'b1; load_val = 2'b00;
        adv(1);
        load = 1'b0; step_btn = 1'b1;
        r = cyc;
        exp_at(r,      "man_load",   c_FULL, 4'b0000);
        exp_at(r + 6,  "man_pre",    c_SEL,  4'b0000);
        exp_at(r + 7,  "man_step",   c_FULL, 4'b0100);
        exp_at(r + 10, "man_tick",   c_FULL, 4'b0101);
        exp_at(r + 20, "man_single", c_SEL,  4'b0100);
        to_cyc(r + 10);
        step_btn = 1'b0;
        to_cyc(r + 20);

        // Bounce, then stable press, then a short release glitch
        b = cyc;
        exp_at(b + 10, "bounce_none",   c_SEL, 4'b0100);
        exp_at(b + 14, "bounce_pre",    c_SEL, 4'b0100);
        exp_at(b + 15, "bounce_step",   c_SEL, 4'b1000);
        exp_at(b + 30, "glitch_nostep", c_SEL, 4'b1000);
        step_btn = 1'b1; to_cyc(b + 2);
        step_btn = 1'b0; to_cyc(b + 4);
        step_btn = 1'b1; to_cyc(b + 6);
        step_btn = 1'b0; to_cyc(b + 8);
        step_btn = 1'b1; to_cyc(b + 20);
        step_btn = 1'b0; to_cyc(b + 22);
        step_btn = 1'b1; to_cyc(b + 30);
        step_btn = 1'b0; to_cyc(b + 40);

        // Reset while the debouncer is qualifying a press
        m = cyc;
        step_btn = 1'b1;
        to_cyc(m + 4);
        rst = 1'b1; step_btn = 1'b0;
        exp_at(m + 5,  "mid_rst",  c_FULL, 4'b0000);
        exp_at(m + 20, "rst_drop", c_SEL,  4'b0000);
        to_cyc(m + 6);
        rst = 1'b0;
        to_cyc(m + 20);
        step_btn = 1'b1;
        r2 = cyc;
        exp_at(r2 + 6, "fresh_pre",   c_SEL, 4'b0000);
        exp_at(r2 + 7, "fresh_press", c_SEL, 4'b0100);
        to_cyc(r2 + 12);
        step_btn = 1'b0;
        to_cyc(r2 + 25);

        adv(2);
        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
